// File: rtl/seg_frame_decoder_if.sv
// Segment-code stream in, decoded digit/frame status out.
// The source side (sequencer or bench) takes master; the decoder takes slave.
interface seg_frame_decoder_if;
   logic [7:0]  seg_in;
   logic        seg_vld;
   logic [3:0]  digit;
   logic        digit_vld;
   logic [2:0]  pos;
   logic [31:0] frame;
   logic        frame_done;
   logic        match_a;
   logic        match_b;
   logic        bad_code;
   logic [7:0]  err_cnt;

   modport master (
      output seg_in, seg_vld,
      input  digit, digit_vld, pos, frame, frame_done,
             match_a, match_b, bad_code, err_cnt
   );
   modport slave (
      input  seg_in, seg_vld,
      output digit, digit_vld, pos, frame, frame_done,
             match_a, match_b, bad_code, err_cnt
   );
endinterface

// File: rtl/seg_frame_decoder.sv
// Decodes 7-segment codes back to digits, assembles 8-digit frames and
// compares each completed frame against two stored reference sequences.
module seg_frame_decoder #(
   parameter logic [31:0] SEQ_A     = 32'h16071017,
   parameter logic [31:0] SEQ_B     = 32'h16071005,
   parameter int          FRAME_LEN = 8
) (
   input  logic               clkc,
   input  logic               clr,
   seg_frame_decoder_if.slave bus
);
   localparam logic [2:0] LAST = 3'(FRAME_LEN - 1);

   typedef enum logic {COLLECT, RESYNC} state_t;

   state_t      state;
   logic [31:0] shbuf;
   logic [3:0]  dec;
   logic        legal;
   logic [31:0] nxt_frame;

   always_comb begin
      dec   = 4'h0;
      legal = 1'b1;
      case (bus.seg_in)
         8'b11111100: dec = 4'h0;
         8'b01100000: dec = 4'h1;
         8'b11011010: dec = 4'h2;
         8'b11110010: dec = 4'h3;
         8'b01100110: dec = 4'h4;
         8'b10110110: dec = 4'h5;
         8'b10111110: dec = 4'h6;
         8'b11100000: dec = 4'h7;
         8'b11111110: dec = 4'h8;
         8'b11110110: dec = 4'h9;
         8'b10011110: dec = 4'hE;
         8'b00000000: dec = 4'hF;
         default:     legal = 1'b0;
      endcase
   end

   // The last slot is never stored; the completed frame is the buffer with
   // the incoming digit spliced into the top nibble.
   assign nxt_frame = {dec, shbuf[27:0]};

   always_ff @(posedge clkc or posedge clr) begin
      if (clr) begin
         state          <= COLLECT;
         shbuf          <= '0;
         bus.digit      <= '0;
         bus.digit_vld  <= 1'b0;
         bus.pos        <= '0;
         bus.frame      <= '0;
         bus.frame_done <= 1'b0;
         bus.match_a    <= 1'b0;
         bus.match_b    <= 1'b0;
         bus.bad_code   <= 1'b0;
         bus.err_cnt    <= '0;
      end else begin
         bus.digit_vld  <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.bad_code   <= 1'b0;
         if (bus.seg_vld) begin
            if (!legal) begin
               bus.bad_code <= 1'b1;
               if (bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
               bus.pos <= '0;
               state   <= RESYNC;
            end else if (dec == 4'hF) begin
               bus.digit     <= 4'hF;
               bus.digit_vld <= 1'b1;
               bus.pos       <= '0;
               state         <= COLLECT;
            end else if (state == COLLECT) begin
               bus.digit     <= dec;
               bus.digit_vld <= 1'b1;
               if (bus.pos == LAST) begin
                  bus.frame      <= nxt_frame;
                  bus.frame_done <= 1'b1;
                  bus.match_a    <= (nxt_frame == SEQ_A);
                  bus.match_b    <= (nxt_frame == SEQ_B);
                  bus.pos        <= '0;
               end else begin
                  shbuf[{bus.pos, 2'b00} +: 4] <= dec;
                  bus.pos <= bus.pos + 3'd1;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_seg_frame_decoder.sv
// Bench for seg_frame_decoder: decode table vectors, directed frame/resync/
// saturation/async-clear sequences, then random traffic against a frame model.
module tb_seg_frame_decoder;
   localparam logic [31:0] SEQ_A = 32'h16071017;
   localparam logic [31:0] SEQ_B = 32'h16071005;

   logic clkc = 1'b0;
   logic clr  = 1'b1;
   always #5 clkc = ~clkc;

   seg_frame_decoder_if bus ();
   seg_frame_decoder #(.SEQ_A(SEQ_A), .SEQ_B(SEQ_B), .FRAME_LEN(8)) dut (
      .clkc(clkc), .clr(clr), .bus(bus)
   );

   int checks = 0;
   int errors = 0;

   // reference model state
   int          q[$];
   bit          rs;
   logic [3:0]  m_digit;
   bit          m_dvld, m_fdone, m_bad, m_ma, m_mb;
   logic [31:0] m_frame;
   int          m_err;

   logic [7:0] codes [12] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6,
                              8'hBE, 8'hE0, 8'hFE, 8'hF6, 8'h9E, 8'h00};
   int         vals  [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 14, 15};

   function automatic int decode(logic [7:0] s);
      for (int i = 0; i < 12; i++) if (codes[i] == s) return vals[i];
      return -1;
   endfunction

   function automatic logic [7:0] enc(int d);
      for (int i = 0; i < 12; i++) if (vals[i] == d) return codes[i];
      return 8'h01;
   endfunction

   task automatic model_reset();
      q.delete(); rs = 0; m_digit = 0; m_dvld = 0; m_fdone = 0; m_bad = 0;
      m_ma = 0; m_mb = 0; m_frame = 0; m_err = 0;
   endtask

   task automatic model_step(logic [7:0] s, logic v);
      int d;
      longint f;
      m_dvld = 0; m_fdone = 0; m_bad = 0;
      if (!v) return;
      d = decode(s);
      if (d < 0) begin
         m_bad = 1; m_err = (m_err < 255) ? m_err + 1 : 255; q.delete(); rs = 1;
      end else if (d == 15) begin
         q.delete(); rs = 0; m_digit = 4'hF; m_dvld = 1;
      end else if (!rs) begin
         m_digit = 4'(d); m_dvld = 1; q.push_back(d);
         if (q.size() == 8) begin
            f = 0;
            for (int k = 0; k < 8; k++) f += longint'(q[k]) * (longint'(1) << (4 * k));
            m_frame = 32'(f); m_fdone = 1;
            m_ma = (m_frame == SEQ_A); m_mb = (m_frame == SEQ_B);
            q.delete();
         end
      end
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      chk("digit",      32'(bus.digit),      32'(m_digit));
      chk("digit_vld",  32'(bus.digit_vld),  32'(m_dvld));
      chk("pos",        32'(bus.pos),        32'(q.size()));
      chk("frame",      bus.frame,           m_frame);
      chk("frame_done", 32'(bus.frame_done), 32'(m_fdone));
      chk("match_a",    32'(bus.match_a),    32'(m_ma));
      chk("match_b",    32'(bus.match_b),    32'(m_mb));
      chk("bad_code",   32'(bus.bad_code),   32'(m_bad));
      chk("err_cnt",    32'(bus.err_cnt),    32'(m_err));
   endtask

   task automatic step(logic [7:0] s, logic v);
      @(negedge clkc);
      bus.seg_in = s; bus.seg_vld = v;
      @(posedge clkc);
      model_step(s, v);
      #1 compare_all();
   endtask

   task automatic send_digits(int d[8]);
      for (int i = 0; i < 8; i++) step(enc(d[i]), 1'b1);
   endtask

   typedef struct {
      logic [7:0] seg;
      logic       dvld;
      logic [3:0] digit;
      logic [2:0] pos;
      logic       bad;
      logic       fdone;
   } vec_t;

   vec_t tbl[16];
   int   seq_a[8] = '{7, 1, 0, 1, 7, 0, 6, 1};
   int   seq_b[8] = '{5, 0, 0, 1, 7, 0, 6, 1};
   int   e0;

   initial begin
      bus.seg_in = 8'h00; bus.seg_vld = 1'b0;
      tbl[0]  = '{8'hFC, 1, 4'h0, 3'd1, 0, 0};
      tbl[1]  = '{8'h60, 1, 4'h1, 3'd2, 0, 0};
      tbl[2]  = '{8'hDA, 1, 4'h2, 3'd3, 0, 0};
      tbl[3]  = '{8'hF2, 1, 4'h3, 3'd4, 0, 0};
      tbl[4]  = '{8'h66, 1, 4'h4, 3'd5, 0, 0};
      tbl[5]  = '{8'hB6, 1, 4'h5, 3'd6, 0, 0};
      tbl[6]  = '{8'hBE, 1, 4'h6, 3'd7, 0, 0};
      tbl[7]  = '{8'hE0, 1, 4'h7, 3'd0, 0, 1};
      tbl[8]  = '{8'hFE, 1, 4'h8, 3'd1, 0, 0};
      tbl[9]  = '{8'hF6, 1, 4'h9, 3'd2, 0, 0};
      tbl[10] = '{8'h9E, 1, 4'hE, 3'd3, 0, 0};
      tbl[11] = '{8'h00, 1, 4'hF, 3'd0, 0, 0};
      tbl[12] = '{8'h01, 0, 4'hF, 3'd0, 1, 0};
      tbl[13] = '{8'hFC, 0, 4'hF, 3'd0, 0, 0};
      tbl[14] = '{8'h00, 1, 4'hF, 3'd0, 0, 0};
      tbl[15] = '{8'hA5, 0, 4'hF, 3'd0, 1, 0};

      model_reset();
      repeat (2) @(negedge clkc);
      #1 compare_all();
      clr = 1'b0;

      // decode table and resync vectors with fixed expectations
      for (int i = 0; i < 16; i++) begin
         step(tbl[i].seg, 1'b1);
         chk("tbl_dvld",  32'(bus.digit_vld),  32'(tbl[i].dvld));
         chk("tbl_digit", 32'(bus.digit),      32'(tbl[i].digit));
         chk("tbl_pos",   32'(bus.pos),        32'(tbl[i].pos));
         chk("tbl_bad",   32'(bus.bad_code),   32'(tbl[i].bad));
         chk("tbl_fdone", 32'(bus.frame_done), 32'(tbl[i].fdone));
         if (i == 7) chk("tbl_frame", bus.frame, 32'h76543210);
      end
      step(8'h00, 1'b1);

      // sequence A
      send_digits(seq_a);
      chk("a_fdone", 32'(bus.frame_done), 1);
      chk("a_frame", bus.frame, SEQ_A);
      chk("a_match_a", 32'(bus.match_a), 1);
      chk("a_match_b", 32'(bus.match_b), 0);
      step(8'h00, 1'b0);
      chk("a_hold", 32'(bus.match_a), 1);

      // sequence B twice back to back
      send_digits(seq_b);
      chk("b1_fdone", 32'(bus.frame_done), 1);
      send_digits(seq_b);
      chk("b2_fdone", 32'(bus.frame_done), 1);
      chk("b_frame", bus.frame, SEQ_B);
      chk("b_match_b", 32'(bus.match_b), 1);
      chk("b_match_a", 32'(bus.match_a), 0);

      // partial, blank, then full A
      step(enc(7), 1'b1); step(enc(1), 1'b1); step(enc(0), 1'b1);
      step(8'h00, 1'b1);
      chk("blank_digit", 32'(bus.digit), 32'hF);
      chk("blank_pos", 32'(bus.pos), 0);
      send_digits(seq_a);
      chk("pa_fdone", 32'(bus.frame_done), 1);
      chk("pa_match_a", 32'(bus.match_a), 1);

      // illegal mid-frame, then digits ignored until a blank
      step(enc(5), 1'b1); step(enc(0), 1'b1);
      e0 = int'(bus.err_cnt);
      step(8'h01, 1'b1);
      chk("ill_bad", 32'(bus.bad_code), 1);
      chk("ill_err", 32'(bus.err_cnt), 32'(e0 + 1));
      step(enc(5), 1'b1);
      chk("rs_dvld", 32'(bus.digit_vld), 0);
      chk("rs_pos", 32'(bus.pos), 0);
      chk("rs_frame", bus.frame, SEQ_A);
      chk("rs_match_a", 32'(bus.match_a), 1);
      step(8'h00, 1'b1);
      chk("rs_exit", 32'(bus.digit_vld), 1);

      // saturation
      for (int i = 0; i < 300; i++) step(8'h01, 1'b1);
      chk("sat_err", 32'(bus.err_cnt), 32'hFF);
      step(8'h00, 1'b1);

      // asynchronous clear mid-frame
      step(enc(7), 1'b1); step(enc(1), 1'b1);
      @(negedge clkc);
      bus.seg_vld = 1'b0;
      #2 clr = 1'b1;
      #1 model_reset();
      compare_all();
      chk("clr_err", 32'(bus.err_cnt), 0);
      #1 clr = 1'b0;
      send_digits(seq_a);
      chk("clr_match_a", 32'(bus.match_a), 1);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 4) send_digits(($urandom_range(0, 1) == 1) ? seq_a : seq_b);
         else if (r < 18) step(8'($urandom), 1'b0);
         else if (r < 28) step(8'h00, 1'b1);
         else if (r < 36) step(8'($urandom) | 8'h01, 1'b1);
         else step(codes[$urandom_range(0, 10)], 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
